// File: rtl/y86_alu_pkg.sv
// Shared types and constants for the Y86-64 execute-stage ALU.
// Op encodings, condition functions and the CC register layout.
package y86_alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/y86_cond_eval.sv
// jXX/cmovXX condition evaluation from a set of flags.
// Purely combinational so the cmov path can reuse it.
module y86_cond_eval
  import y86_alu_pkg::*;
(
  input  cc_t        cc,
  input  logic [3:0] cond_fn,
  output logic       cnd
);

  logic lt;

  assign lt = cc.sf ^ cc.of;

  always_comb begin
    cnd = 1'b0;
    case (cond_fn)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | cc.zf;
      C_L:      cnd = lt;
      C_E:      cnd = cc.zf;
      C_NE:     cnd = ~cc.zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~cc.zf;
      default:  cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_alu.sv
// Y86-64 execute ALU: add/sub and and/xor results, overflow,
// condition-code register and branch/cmov condition output.
module y86_alu
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] ans,
  output logic             overflow,
  input  logic             set_cc,
  input  logic [3:0]       cond_fn,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cnd
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] res;
  logic             same_sign;
  logic             sign_flip;
  cc_t              cc_q;
  cc_t              cc_d;

  assign S   = control[0] ? (A - B) : (A + B);
  assign ans = control[0] ? (A ^ B) : (A & B);

  // Sub overflows when operand signs differ, add when they match.
  assign same_sign = (A[MSB] == B[MSB]);
  assign sign_flip = (S[MSB] != A[MSB]);

  assign overflow = ~control[1]
                  & (control[0] ? ~same_sign : same_sign)
                  & sign_flip;

  assign res = control[1] ? ans : S;

  assign cc_d.zf = (res == '0);
  assign cc_d.sf = res[MSB];
  assign cc_d.of = overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= '0;
    end else if (set_cc) begin
      cc_q <= cc_d;
    end
  end

  assign zf = cc_q.zf;
  assign sf = cc_q.sf;
  assign of = cc_q.of;

  y86_cond_eval u_cond (
    .cc      (cc_q),
    .cond_fn (cond_fn),
    .cnd     (cnd)
  );

endmodule

// File: tb/tb_y86_alu.sv
// Scoreboard bench for y86_alu: directed plan vectors then random
// traffic against an arithmetic reference model.
module tb_y86_alu;

  logic        clk;
  logic        rst_n;
  logic [1:0]  control;
  logic [63:0] A;
  logic [63:0] B;
  logic [63:0] S;
  logic [63:0] ans;
  logic        overflow;
  logic        set_cc;
  logic [3:0]  cond_fn;
  logic        zf;
  logic        sf;
  logic        of;
  logic        cnd;

  y86_alu #(.WIDTH(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .control  (control),
    .A        (A),
    .B        (B),
    .S        (S),
    .ans      (ans),
    .overflow (overflow),
    .set_cc   (set_cc),
    .cond_fn  (cond_fn),
    .zf       (zf),
    .sf       (sf),
    .of       (of),
    .cnd      (cnd)
  );

  typedef struct {
    logic [63:0] s;
    logic [63:0] a;
    logic        ovf;
    logic        zf;
    logic        sf;
    logic        of;
    logic        cnd;
  } exp_t;

  exp_t q[$];

  int vectors = 0;
  int miscompares = 0;

  // Model flag state, updated at edges the model decides load.
  logic m_zf = 0;
  logic m_sf = 0;
  logic m_of = 0;

  localparam logic signed [65:0] MAXV = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] MINV = -MAXV - 66'sd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cond_ref(input logic [3:0] fn,
                                    input logic z,
                                    input logic s,
                                    input logic o);
    logic less;
    less = (s != o);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return less || z;
      4'd2: return less;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !less;
      4'd6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply(input logic [1:0] ctl,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic ld,
                       input logic [3:0] fn,
                       input logic rst);
    exp_t e;
    logic signed [65:0] wa;
    logic signed [65:0] wb;
    logic signed [65:0] full;
    logic [63:0] r;
    control = ctl;
    A = a;
    B = b;
    set_cc = ld;
    cond_fn = fn;
    rst_n = rst;
    if (!rst) begin
      m_zf = 0;
      m_sf = 0;
      m_of = 0;
    end
    wa = $signed({{2{a[63]}}, a});
    wb = $signed({{2{b[63]}}, b});
    full = ctl[0] ? (wa - wb) : (wa + wb);
    e.s = ctl[0] ? (a - b) : (a + b);
    e.a = ctl[0] ? (a ^ b) : (a & b);
    e.ovf = !ctl[1] && ((full > MAXV) || (full < MINV));
    e.zf = m_zf;
    e.sf = m_sf;
    e.of = m_of;
    e.cnd = cond_ref(fn, m_zf, m_sf, m_of);
    q.push_back(e);
    r = ctl[1] ? e.a : e.s;
    @(posedge clk);
    #1;
    if (ld && rst) begin
      m_zf = (r == 64'd0);
      m_sf = r[63];
      m_of = e.ovf;
    end
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: outputs settle between the drive point and the next edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      chk("S", S, e.s);
      chk("ans", ans, e.a);
      chk("overflow", {63'd0, overflow}, {63'd0, e.ovf});
      chk("zf", {63'd0, zf}, {63'd0, e.zf});
      chk("sf", {63'd0, sf}, {63'd0, e.sf});
      chk("of", {63'd0, of}, {63'd0, e.of});
      chk("cnd", {63'd0, cnd}, {63'd0, e.cnd});
    end
  end

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'h7FFF_FFFF_FFFF_FFFF;
      1: v = 64'h8000_0000_0000_0000;
      2: v = 64'hFFFF_FFFF_FFFF_FFFF;
      3: v = 64'd0;
      4: v = 64'd1;
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] ra;
    control = 2'b00;
    A = '0;
    B = '0;
    set_cc = 1'b0;
    cond_fn = 4'd0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    // Reset state, with a load request that must be ignored.
    apply(2'b00, 64'd5, 64'd7, 1'b1, 4'd0, 1'b0);
    for (int f = 0; f < 7; f++)
      apply(2'b00, 64'd5, 64'd7, 1'b0, f[3:0], 1'b1);
    // Add
    apply(2'b00, 64'd5, 64'd7, 1'b1, 4'd6, 1'b1);
    apply(2'b00, 64'd5, 64'd7, 1'b0, 4'd6, 1'b1);
    // Add overflow
    apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd2, 1'b1);
    apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd2, 1'b1);
    apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd5, 1'b1);
    // Sub to zero
    apply(2'b01, 64'd3, 64'd3, 1'b1, 4'd3, 1'b1);
    apply(2'b01, 64'd3, 64'd3, 1'b0, 4'd3, 1'b1);
    apply(2'b01, 64'd3, 64'd3, 1'b0, 4'd4, 1'b1);
    apply(2'b01, 64'd3, 64'd3, 1'b0, 4'd1, 1'b1);
    // Sub overflow and wrap
    apply(2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 4'd0, 1'b1);
    apply(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd0, 1'b1);
    // Logic ops
    apply(2'b10, 64'hF0F0, 64'h0FF0, 1'b0, 4'd0, 1'b1);
    apply(2'b11, 64'hF0F0, 64'h0FF0, 1'b0, 4'd0, 1'b1);
    apply(2'b10, 64'hF0F0, 64'h0F0F, 1'b1, 4'd3, 1'b1);
    apply(2'b10, 64'hF0F0, 64'h0F0F, 1'b0, 4'd3, 1'b1);
    // Reset while flags hold sf=1, of=1
    apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd0, 1'b1);
    apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd0, 1'b1);
    apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd0, 1'b0);
    apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++)
      apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd0, 1'b1);
    apply(2'b01, 64'd9, 64'd2, 1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++)
      apply(2'b11, 64'd0, 64'd0, 1'b0, 4'd6, 1'b1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      ra = pick();
      apply(2'($urandom_range(0, 3)), ra,
            ($urandom_range(0, 7) == 0) ? ra : pick(),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 49) != 0));
    end
    for (int w = 0; w < 10 && q.size() > 0; w++)
      @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
